// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   - operation encodings on the 2-bit op port
//   - FSM state type
//   - iteration counter width helper
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int md_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (combinational).
//   acc_in  : {upper, lower} accumulator. Multiply: {partial product, multiplier
//             bits not yet consumed}. Divide: {partial remainder, dividend bits
//             not yet consumed / quotient bits produced so far}.
//   operand : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   is_div  : 1 selects a restoring-division step, 0 a shift-add step
//   acc_out : next accumulator; for divide bit 0 is left clear for q_bit
//   q_bit   : quotient bit produced by this divide step (0 for multiply)
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_out,
  output logic               q_bit
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    add_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    // Remainder shifted left by one with the next dividend bit brought in.
    trial   = acc_in[2*WIDTH-1:WIDTH-1];
    // The remainder is always below the divisor, so the top bit of diff is a
    // clean borrow flag.
    diff    = trial - {1'b0, operand};
    q_bit   = 1'b0;
    acc_out = {add_sum, acc_in[WIDTH-1:1]};
    if (is_div) begin
      q_bit   = ~diff[WIDTH];
      acc_out = {(diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0]),
                 acc_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One bit per clock; start/busy/done handshake; move-to writes via hi_we/lo_we.
//   clk, rst            : clock, asynchronous active-high reset
//   start, op, op_a/b   : operation request, sampled while busy=0
//   abort               : drop the operation in flight, no result written
//   hi_we, lo_we, wdata : move-to-HI/LO, only while busy=0
//   busy, done          : in-flight flag, one-cycle completion pulse
//   div_zero            : with done, divide by zero (hi/lo left unchanged)
//   hi, lo              : product upper/lower half, or remainder/quotient
//
// state | meaning
// IDLE  | no operation; accepts start and move-to writes
// CALC  | one multiply or divide step per clock, counter counting down
// FIX   | sign correction and HI/LO write-back (or divide-by-zero report)
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = md_cnt_width(WIDTH);

  md_state_t          state, state_nxt;
  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               div_r, sign_a, sign_b, dz_r;

  logic               accept, step_en, fix_en, mt_en, busy_nxt;
  logic               op_signed, sgn_a_in, sgn_b_in, dz_in;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;
  logic [2*WIDTH-1:0] step_acc, prod_fix;
  logic               step_q;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign sgn_a_in  = op_signed & op_a[WIDTH-1];
  assign sgn_b_in  = op_signed & op_b[WIDTH-1];
  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude.
  assign a_mag_in  = sgn_a_in ? -op_a : op_a;
  assign b_mag_in  = sgn_b_in ? -op_b : op_b;
  assign dz_in     = op[1] && (op_b == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !abort) state_nxt = dz_in ? FIX : CALC;
      CALC: begin
        if (abort)                    state_nxt = IDLE;
        else if (counter == CW'(1))   state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    step_en = 1'b0;
    fix_en  = 1'b0;
    mt_en   = 1'b0;
    case (state)
      IDLE: begin
        accept = start & ~abort;
        mt_en  = 1'b1;
      end
      CALC:    step_en = ~abort;
      FIX:     fix_en  = ~abort;
      default: ;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc),
    .operand (opnd),
    .is_div  (div_r),
    .acc_out (step_acc),
    .q_bit   (step_q)
  );

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (div_r) begin
      lo_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      hi_fix = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter  <= '0;
      acc      <= '0;
      opnd     <= '0;
      div_r    <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      dz_r     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      busy     <= busy_nxt;
      done     <= fix_en;
      div_zero <= fix_en & dz_r;
      if (accept) begin
        div_r   <= op[1];
        sign_a  <= sgn_a_in;
        sign_b  <= sgn_b_in;
        dz_r    <= dz_in;
        // Multiply iterates over the multiplier bits, divide over the dividend.
        opnd    <= op[1] ? b_mag_in : a_mag_in;
        acc     <= {{WIDTH{1'b0}}, (op[1] ? a_mag_in : b_mag_in)};
        counter <= dz_in ? '0 : CW'(WIDTH);
      end else if (step_en) begin
        acc     <= {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
        counter <= counter - CW'(1);
      end
      if (fix_en && !dz_r) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end else if (mt_en) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (WIDTH=32): directed cases plus random
// operations compared against a plain-arithmetic reference model of HI/LO.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] op_a = '0, op_b = '0;
  logic        abort = 1'b0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: result of one operation on the architectural HI/LO, using
  // 64-bit arithmetic (SV / and % truncate toward zero like the hardware).
  task automatic model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic dz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    case (o)
      2'b00: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      default: begin
        if (b == 0) dz = 1'b1;
        else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb;
          m_lo = 32'(q); m_hi = 32'(r);
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
    endcase
  endtask

  // Called just after a rising edge; start is seen on the next edge (edge 0).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic whi, input logic wlo,
                        input logic [31:0] wd);
    logic exp_dz;
    int   n;
    start = 1'b1; op = o; op_a = a; op_b = b;
    hi_we = whi; lo_we = wlo; wdata = wd;
    if (whi) m_hi = wd;
    if (wlo) m_lo = wd;
    model_op(o, a, b, exp_dz);
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check({tag, "_busy_acc"}, 64'(busy), 64'(1));
    n = 0;
    while (n < 80) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    check({tag, "_latency"}, 64'(n), exp_dz ? 64'(1) : 64'(33));
    check({tag, "_busy_done"}, 64'(busy), 64'(0));
    check({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  task automatic mt_write(input logic whi, input logic wlo, input logic [31:0] wd);
    hi_we = whi; lo_we = wlo; wdata = wd;
    if (whi) m_hi = wd;
    if (wlo) m_lo = wd;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [1:0]  rw;
    int          dcount;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, '0);
    check("mult_neg_hi_k", 64'(hi), 64'hFFFFFFFF);
    check("mult_neg_lo_k", 64'(lo), 64'hFFFFFFEB);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
    check("multu_max_hi_k", 64'(hi), 64'hFFFFFFFE);
    // Back-to-back: issued in the done cycle of the previous operation.
    run_op("multu_b2b", 2'b01, 32'd2, 32'd3, 1'b0, 1'b0, '0);
    check("multu_b2b_lo_k", 64'(lo), 64'd6);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, '0);
    check("div_neg_lo_k", 64'(lo), 64'hFFFFFFFD);
    run_op("div_minm1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
    check("div_minm1_lo_k", 64'(lo), 64'h80000000);

    mt_write(1'b1, 1'b0, 32'h11);
    mt_write(1'b0, 1'b1, 32'h22);
    check("mt_hi", 64'(hi), 64'h11);
    check("mt_lo", 64'(lo), 64'h22);
    run_op("divu_zero", 2'b11, 32'd5, 32'd0, 1'b0, 1'b0, '0);
    check("divu_zero_hi_k", 64'(hi), 64'h11);

    // Move-to write together with an accepted start: write lands first, the
    // operation uses the latched operands.
    run_op("mt_with_start", 2'b11, 32'd50, 32'd0, 1'b1, 1'b1, 32'hABCD);
    check("mt_with_start_hi_k", 64'(hi), 64'hABCD);

    // Abort at cycle 10 of a MULT with an ignored start and a dropped hi_we.
    start = 1'b1; op = 2'b00; op_a = 32'd1234; op_b = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) begin
        start = 1'b1; op = 2'b11; op_a = 32'd9; op_b = 32'd0;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
      end
      if (k == 4) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("abort_busy_before", 64'(busy), 64'(1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dcount++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 64'(dcount), 64'(0));
    check("abort_hi", 64'(hi), 64'(m_hi));
    check("abort_lo", 64'(lo), 64'(m_lo));

    // Abort in IDLE cancels a simultaneous start.
    start = 1'b1; abort = 1'b1; op = 2'b01; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      rw = 2'($urandom_range(0, 3));
      run_op("rnd", ro, ra, rb, rw[1], rw[0], $urandom);
    end

    // Asynchronous reset in the middle of CALC.
    start = 1'b1; op = 2'b10; op_a = 32'd999; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_hi", 64'(hi), 64'(0));
    check("arst_lo", 64'(lo), 64'(0));
    m_hi = '0; m_lo = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, '0);
    check("divu_100_7_lo_k", 64'(lo), 64'd14);
    check("divu_100_7_hi_k", 64'(hi), 64'd2);

    @(posedge clk); #1;
    check("done_pulse_end", 64'(done), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
